video_upscaler_2x2: RTL and testbench



---
 rtl/video_upscaler_2x2.sv | 137 +++++++++++++
 tb/tb_video_upscaler_2x2.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_upscaler_2x2.sv
// 2x2 pixel-replicating upscaler on AXI-Stream video (tuser = start-of-frame, tlast = end-of-line).
// Each input pixel is emitted twice, and each completed line is then replayed once from a line buffer.
module video_upscaler_2x2 #(
  parameter int D_WIDTH  = 8,
  parameter int MAX_LINE = 1024,
  localparam int ADDR_WIDTH = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready
);

  typedef enum logic [1:0] {WAIT_SOF, LINE0, LINE1} state_t;

  state_t                state;
  logic [D_WIDTH-1:0]    line_buf [MAX_LINE];
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic [ADDR_WIDTH-1:0] pix_idx;
  logic                  copy;
  logic                  last_pix;
  logic                  out_fire;
  logic                  slot_free;
  logic                  in_fire;
  logic                  load_px;
  logic                  pix_last;

  // The holding register may take a new pixel once it is empty or its second copy is leaving,
  // except after the line's last pixel, when the replay has to start instead.
  assign out_fire  = down_valid && down_ready;
  assign slot_free = !down_valid || (copy && down_ready && !last_pix);

  always_comb begin
    up_ready = 1'b0;
    if (!rst) begin
      case (state)
        WAIT_SOF: up_ready = 1'b1;
        LINE0:    up_ready = slot_free;
        default:  up_ready = 1'b0;
      endcase
    end
  end

  assign in_fire  = up_valid && up_ready;
  assign load_px  = in_fire && ((state == LINE0) || up_tuser);
  assign pix_idx  = up_tuser ? '0 : wr_idx;
  assign pix_last = up_tlast || (pix_idx == ADDR_WIDTH'(MAX_LINE - 1));
  assign next_ptr = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (load_px) begin
      line_buf[pix_idx] <= up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SOF;
      down_data  <= '0;
      down_valid <= 1'b0;
      down_tlast <= 1'b0;
      down_tuser <= 1'b0;
      copy       <= 1'b0;
      last_pix   <= 1'b0;
      wr_idx     <= '0;
      last_idx   <= '0;
      rd_ptr     <= '0;
    end else if (load_px) begin
      // A tuser pixel always restarts the line at index 0, dropping any partial line.
      state      <= LINE0;
      down_data  <= up_data;
      down_valid <= 1'b1;
      down_tuser <= up_tuser;
      down_tlast <= 1'b0;
      copy       <= 1'b0;
      last_pix   <= pix_last;
      wr_idx     <= pix_last ? '0 : pix_idx + 1'b1;
      if (pix_last) begin
        last_idx <= pix_idx;
      end
    end else begin
      case (state)
        LINE0: begin
          if (out_fire) begin
            if (!copy) begin
              copy       <= 1'b1;
              down_tuser <= 1'b0;
              down_tlast <= last_pix;
            end else if (last_pix) begin
              // Buffer slot 0 was written well before now, so the replay starts with no bubble.
              state      <= LINE1;
              down_data  <= line_buf[0];
              down_tlast <= 1'b0;
              copy       <= 1'b0;
              last_pix   <= 1'b0;
              rd_ptr     <= '0;
            end else begin
              down_valid <= 1'b0;
              down_tlast <= 1'b0;
            end
          end
        end
        LINE1: begin
          if (out_fire) begin
            if (!copy) begin
              copy       <= 1'b1;
              down_tlast <= (rd_ptr == last_idx);
            end else if (rd_ptr == last_idx) begin
              state      <= LINE0;
              down_valid <= 1'b0;
              down_tlast <= 1'b0;
              copy       <= 1'b0;
            end else begin
              rd_ptr     <= next_ptr;
              down_data  <= line_buf[next_ptr];
              down_tlast <= 1'b0;
              copy       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_video_upscaler_2x2.sv
// Randomised bench for video_upscaler_2x2: a frame-level model predicts every output beat.
module tb_video_upscaler_2x2;

  localparam int DW = 8;
  localparam int ML = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] up_data = '0;
  logic          up_valid = 1'b0;
  logic          up_tlast = 1'b0;
  logic          up_tuser = 1'b0;
  logic          up_ready;
  logic [DW-1:0] down_data;
  logic          down_valid;
  logic          down_tlast;
  logic          down_tuser;
  logic          down_ready = 1'b1;

  beat_t stim_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    ready_mode = 1'b0;
  int    rcyc = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  video_upscaler_2x2 #(.D_WIDTH(DW), .MAX_LINE(ML)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_ready(up_ready),
    .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
    .down_tuser(down_tuser), .down_ready(down_ready)
  );

  // Sink readiness: always ready, or the repeating 1,0,0,1 pattern.
  initial forever begin
    @(posedge clk);
    #1;
    rcyc++;
    down_ready = ready_mode ? ((rcyc % 4 == 0) || (rcyc % 4 == 3)) : 1'b1;
  end

  // Output monitor: collects completed beats and checks that stalled beats hold still.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!down_valid || beat_t'({down_data, down_tuser, down_tlast}) !== prev_beat) begin
          errors++;
          $display("[TB] FAIL stall_stable: got valid=%0b beat=%h required valid=1 beat=%h",
                   down_valid, {down_data, down_tuser, down_tlast}, prev_beat);
        end
      end
      if (down_valid && down_ready) got_q.push_back(beat_t'({down_data, down_tuser, down_tlast}));
      prev_stall = down_valid && !down_ready;
      prev_beat  = beat_t'({down_data, down_tuser, down_tlast});
    end
  end

  // Reference model: works on whole lines of accepted pixels rather than on cycles.
  task automatic build_expected();
    logic [DW-1:0] line[$];
    bit            in_frame = 1'b0;
    bit            last;
    exp_q.delete();
    foreach (stim_q[i]) begin
      if (stim_q[i].sof) begin
        in_frame = 1'b1;
        line.delete();
      end
      if (in_frame) begin
        line.push_back(stim_q[i].data);
        last = stim_q[i].eol || (line.size() == ML);
        exp_q.push_back('{stim_q[i].data, stim_q[i].sof, 1'b0});
        exp_q.push_back('{stim_q[i].data, 1'b0, last});
        if (last) begin
          foreach (line[j]) begin
            exp_q.push_back('{line[j], 1'b0, 1'b0});
            exp_q.push_back('{line[j], 1'b0, j == line.size() - 1});
          end
          line.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_valid = 1'b0; up_tuser = 1'b0; up_tlast = 1'b0; up_data = '0;
    ready_mode = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    got_q.delete();
    stim_q.delete();
  endtask

  task automatic applyStimulus(input bit rnd, input int stop_at);
    int waited;
    bit acc;
    foreach (stim_q[i]) begin
      if (rnd) begin
        up_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      up_valid = 1'b1;
      {up_data, up_tuser, up_tlast} = stim_q[i];
      waited = 0;
      do begin
        @(negedge clk); acc = up_ready; @(posedge clk); #1; waited++;
      end while (!acc && waited < 300);
      if (!acc) begin
        checks++; errors++;
        $display("[TB] FAIL input_accept %0d: got up_ready=0 for 300 cycles required 1", i);
      end
    end
    up_valid = 1'b0; up_tuser = 1'b0; up_tlast = 1'b0;
    waited = 0;
    while (got_q.size() < stop_at && waited < 600) begin @(posedge clk); #1; waited++; end
    if (stop_at >= exp_q.size()) repeat (10) begin @(posedge clk); #1; end
  endtask

  task automatic load_basic();
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = DW'((i + 1) * 10);
      stim_q.push_back('{v, i == 0, (i % 4) == 3});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (down_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", down_valid); end
    if (down_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h required 00", down_data); end
    if (down_tuser !== 1'b0) begin errors++; $display("[TB] FAIL reset_tuser: got %b required 0", down_tuser); end
    if (down_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b required 0", down_tlast); end
    if (up_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_up_ready: got %b required 0", up_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("[TB] FAIL wait_sof_ready: got %b required 1", up_ready); end
  endtask

  task automatic test_basic_frame();
    int sof_cnt = 0;
    do_reset();
    load_basic();
    build_expected();
    applyStimulus(1'b0, exp_q.size());
    checks++;
    if (got_q.size() != 32) begin errors++; $display("[TB] FAIL basic_count: got %0d required 32", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL basic beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    foreach (got_q[i]) if (got_q[i].sof) sof_cnt++;
    checks++;
    if (sof_cnt != 1) begin errors++; $display("[TB] FAIL basic_tuser_count: got %0d required 1", sof_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1'b1;
    load_basic();
    build_expected();
    applyStimulus(1'b1, exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL bp beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_pre_sof_junk();
    do_reset();
    repeat (3) stim_q.push_back('{8'hAA, 1'b0, 1'b0});
    load_basic();
    build_expected();
    applyStimulus(1'b1, exp_q.size());
    checks++;
    if (got_q.size() == 0 || got_q[0] !== beat_t'({8'd10, 1'b1, 1'b0})) begin
      errors++; $display("[TB] FAIL junk_first_beat: got %h required %h", got_q[0], beat_t'({8'd10, 1'b1, 1'b0}));
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL junk beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_forced_eol();
    do_reset();
    for (int i = 1; i <= 6; i++) stim_q.push_back('{DW'(i), i == 1, i == 6});
    build_expected();
    applyStimulus(1'b0, exp_q.size());
    checks++;
    if (got_q.size() != 24) begin errors++; $display("[TB] FAIL forced_eol_count: got %0d required 24", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL forced_eol beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_line_sof();
    do_reset();
    stim_q.push_back('{8'd10, 1'b1, 1'b0});
    stim_q.push_back('{8'd20, 1'b0, 1'b0});
    stim_q.push_back('{8'd99, 1'b1, 1'b0});
    stim_q.push_back('{8'd98, 1'b0, 1'b0});
    stim_q.push_back('{8'd97, 1'b0, 1'b0});
    stim_q.push_back('{8'd96, 1'b0, 1'b1});
    build_expected();
    applyStimulus(1'b1, exp_q.size());
    checks++;
    if (got_q.size() != 20) begin errors++; $display("[TB] FAIL mid_sof_count: got %0d required 20", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL mid_sof beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_pixel_lines();
    do_reset();
    ready_mode = 1'b1;
    stim_q.push_back('{8'h07, 1'b1, 1'b1});
    stim_q.push_back('{8'h08, 1'b0, 1'b1});
    stim_q.push_back('{8'h09, 1'b0, 1'b1});
    build_expected();
    applyStimulus(1'b0, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL single_px beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    beat_t b;
    int    len;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      ready_mode = r[0];
      repeat ($urandom_range(0, 3)) stim_q.push_back('{DW'($urandom), 1'b0, 1'($urandom)});
      for (int f = 0; f < 6; f++) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          b.data = DW'($urandom);
          b.sof  = (f == 0 && i == 0) || ($urandom_range(0, 9) == 0);
          b.eol  = (i == len - 1);
          stim_q.push_back(b);
        end
      end
      build_expected();
      applyStimulus(1'b1, exp_q.size());
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d required %0d", r, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("[TB] FAIL rand%0d beat %0d: got %h required %h", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_in_replay();
    do_reset();
    stim_q.push_back('{8'h05, 1'b1, 1'b0});
    stim_q.push_back('{8'h06, 1'b0, 1'b0});
    stim_q.push_back('{8'h07, 1'b0, 1'b1});
    build_expected();
    applyStimulus(1'b0, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (down_valid !== 1'b0) begin errors++; $display("[TB] FAIL replay_reset_valid: got %b required 0", down_valid); end
    if (up_ready !== 1'b1) begin errors++; $display("[TB] FAIL replay_reset_ready: got %b required 1", up_ready); end
    @(posedge clk); #1;
    got_q.delete();
    stim_q.delete();
    load_basic();
    build_expected();
    applyStimulus(1'b1, exp_q.size());
    checks++;
    if (got_q.size() != 32) begin errors++; $display("[TB] FAIL after_reset_count: got %0d required 32", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL after_reset beat %0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_pre_sof_junk();
    test_forced_eol();
    test_mid_line_sof();
    test_single_pixel_lines();
    test_random_frames();
    test_reset_in_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
